// File: rtl/vga_sync_decoder.sv
// Recovers the pixel position (Column/Row/Display) from externally generated VGA
// sync signals and checks the incoming timing against the configured geometry.
module vga_sync_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic       pxclk,
  input  logic       rst_n,
  input  logic       vga_h_sync,
  input  logic       vga_v_sync,
  output logic       Display,
  output logic [9:0] Column,
  output logic [9:0] Row,
  output logic       locked,
  output logic       line_err,
  output logic [7:0] err_count,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] CNT_MAX   = 10'h3FF;
  localparam logic [9:0] H_TOTAL_C = 10'(H_TOTAL);
  localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
  localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0] H_START   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END     = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_START   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END     = 10'(V_SYNC + V_BACK + V_ACTIVE);

  state_t     state;
  logic       hs_q, hs_q_d, vs_q, vs_q_d;
  logic [9:0] hcnt, vcnt, hlow, hlow_last;
  logic       frame_bad;

  logic       hs_fall, hs_rise, vs_fall;
  logic [9:0] hcnt_inc, vcnt_inc, hlow_inc, frame_cnt;
  logic       line_bad, frame_fail, sync_loss, err_event, active;

  assign hs_fall = hs_q_d & ~hs_q;
  assign hs_rise = ~hs_q_d & hs_q;
  assign vs_fall = vs_q_d & ~vs_q;

  assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1;
  assign vcnt_inc = (vcnt == CNT_MAX) ? vcnt : vcnt + 10'd1;
  assign hlow_inc = (hlow == CNT_MAX) ? hlow : hlow + 10'd1;

  // hcnt+1 at a fall is the fall-to-fall period that is about to be latched.
  assign line_bad = hs_fall & ((hcnt_inc != H_TOTAL_C) | (hlow_last != H_SYNC_C));

  // A coincident hsync fall still belongs to the frame being closed.
  assign frame_cnt  = hs_fall ? vcnt_inc : vcnt;
  assign frame_fail = vs_fall & ((frame_cnt != V_TOTAL_C) | frame_bad | line_bad);

  // Fires once, on the edge where hcnt would first reach saturation.
  assign sync_loss = (hcnt == CNT_MAX - 10'd1) & ~hs_fall;
  assign err_event = (state != SEARCH) & (line_bad | frame_fail | sync_loss);

  assign active = (hcnt >= H_START) && (hcnt < H_END) &&
                  (vcnt >= V_START) && (vcnt < V_END);

  assign fsm_state = state;

  always_ff @(posedge pxclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      hs_q        <= 1'b1;
      hs_q_d      <= 1'b1;
      vs_q        <= 1'b1;
      vs_q_d      <= 1'b1;
      hcnt        <= '0;
      vcnt        <= '0;
      hlow        <= '0;
      hlow_last   <= '0;
      frame_bad   <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      err_count   <= '0;
      line_err    <= 1'b0;
      locked      <= 1'b0;
      Display     <= 1'b0;
      Column      <= '0;
      Row         <= '0;
    end else begin
      hs_q   <= vga_h_sync;
      hs_q_d <= hs_q;
      vs_q   <= vga_v_sync;
      vs_q_d <= vs_q;

      hcnt <= hs_fall ? '0 : hcnt_inc;
      if (hs_fall) line_len <= hcnt_inc;

      hlow <= hs_q ? '0 : hlow_inc;
      if (hs_rise) hlow_last <= hlow;

      if (vs_fall) begin
        frame_lines <= frame_cnt;
        vcnt        <= '0;
      end else if (hs_fall) begin
        vcnt <= vcnt_inc;
      end

      if (vs_fall) frame_bad <= 1'b0;
      else if (line_bad | sync_loss) frame_bad <= 1'b1;

      line_err <= err_event;
      if (err_event && err_count != 8'hFF) err_count <= err_count + 8'd1;

      unique case (state)
        SEARCH: begin
          if (vs_fall) state <= VERIFY;
        end
        VERIFY: begin
          if (vs_fall && !frame_fail) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (line_bad | frame_fail | sync_loss) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase

      Display <= active & locked;
      Column  <= active ? hcnt - H_START : '0;
      Row     <= active ? vcnt - V_START : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: drives a reduced-geometry sync stream and checks
// lock acquisition, pixel recovery and error handling.
module tb_vga_sync_decoder;

  localparam int HT = 100, HS = 12, HB = 8, HA = 64;
  localparam int VT = 16, VS = 2, VB = 3, VA = 8;
  localparam int PIX_LAT  = HS + HB + 3;
  localparam int LOSS_LAT = 2 + 1023;
  localparam logic [1:0] ST_SEARCH = 2'd0, ST_VERIFY = 2'd1;

  logic       pxclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic       Display, locked, line_err;
  logic [9:0] Column, Row, line_len, frame_lines;
  logic [7:0] err_count;
  logic [1:0] fsm_state;
  logic [52:0] all_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_pulses = 0;
  int last_err_cyc = -1;
  int disp_total = 0;
  int first_disp_cyc = -1;
  int first_act_fall = -1;
  int p0;
  bit mon_en = 1'b0;
  bit push_en = 1'b0;
  int fall_at [VT];
  logic [19:0] exp_q[$];

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA)
  ) dut (
    .pxclk(pxclk), .rst_n(rst_n), .vga_h_sync(hsync), .vga_v_sync(vsync),
    .Display(Display), .Column(Column), .Row(Row), .locked(locked),
    .line_err(line_err), .err_count(err_count), .line_len(line_len),
    .frame_lines(frame_lines), .fsm_state(fsm_state)
  );

  assign all_out = {Display, Column, Row, locked, line_err, err_count,
                    line_len, frame_lines, fsm_state};

  // clock / reset
  always #5 pxclk = ~pxclk;
  always @(posedge pxclk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // One line of sync stream; observes outputs each cycle before driving.
  task automatic drive_line(input int line, input int len);
    logic [19:0] exp, got;
    for (int i = 0; i < len; i++) begin
      @(negedge pxclk);
      if (line_err) begin
        err_pulses++;
        last_err_cyc = cyc;
      end
      if (mon_en && Display) begin
        disp_total++;
        if (first_disp_cyc < 0) first_disp_cyc = cyc;
        got = {Row, Column};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pixel_extra: got row %0d col %0d, required Display low", Row, Column);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL pixel: got row %0d col %0d, required row %0d col %0d",
                     got[19:10], got[9:0], exp[19:10], exp[9:0]);
          end
        end
      end
      if (i == 0) begin
        fall_at[line] = cyc;
        if (push_en && line >= VS + VB && line < VS + VB + VA) begin
          if (first_act_fall < 0) first_act_fall = cyc;
          for (int c = 0; c < HA; c++) exp_q.push_back({10'(line - VS - VB), 10'(c)});
        end
      end
      hsync = (i >= HS);
      vsync = (line >= VS);
    end
  endtask

  task automatic drive_lines(input int first, input int last, input int odd_line, input int odd_len);
    for (int l = first; l <= last; l++) drive_line(l, (l == odd_line) ? odd_len : HT);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge pxclk);
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
  endtask

  task automatic test_acquire();
    @(negedge pxclk);
    rst_n = 1'b1;
    repeat (3) @(negedge pxclk);
    drive_lines(5, VT - 1, -1, 0);
    tests++;
    if (fsm_state !== ST_SEARCH) begin
      fails++;
      $display("FAIL acq_search: got state %0d, required %0d", fsm_state, ST_SEARCH);
    end
    drive_lines(0, VT - 1, -1, 0);
    tests++;
    if ({fsm_state, locked} !== {ST_VERIFY, 1'b0}) begin
      fails++;
      $display("FAIL acq_verify: got state %0d locked %b, required %0d 0", fsm_state, locked, ST_VERIFY);
    end
    drive_lines(0, VT - 1, -1, 0);
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL acq_locked: got %b, required 1", locked);
    end
    tests++;
    if (line_len !== 10'(HT)) begin
      fails++;
      $display("FAIL acq_line_len: got %0d, required %0d", line_len, HT);
    end
    tests++;
    if (frame_lines !== 10'(VT)) begin
      fails++;
      $display("FAIL acq_frame_lines: got %0d, required %0d", frame_lines, VT);
    end
    tests++;
    if (err_count !== 8'd0 || err_pulses != 0) begin
      fails++;
      $display("FAIL acq_errors: got count %0d pulses %0d, required 0 0", err_count, err_pulses);
    end
  endtask

  task automatic test_display();
    exp_q.delete();
    disp_total = 0;
    first_disp_cyc = -1;
    first_act_fall = -1;
    push_en = 1'b1;
    mon_en  = 1'b1;
    drive_lines(0, VT - 1, -1, 0);
    push_en = 1'b0;
    mon_en  = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL disp_missing: got %0d pixels unseen, required 0", exp_q.size());
    end
    tests++;
    if (disp_total != HA * VA) begin
      fails++;
      $display("FAIL disp_total: got %0d, required %0d", disp_total, HA * VA);
    end
    tests++;
    if (first_disp_cyc - first_act_fall != PIX_LAT) begin
      fails++;
      $display("FAIL disp_latency: got %0d, required %0d", first_disp_cyc - first_act_fall, PIX_LAT);
    end
  endtask

  task automatic test_stretch();
    p0 = err_pulses;
    drive_lines(0, VT - 1, 8, HT + 1);
    tests++;
    if (err_pulses - p0 != 1 || last_err_cyc != fall_at[9] + 2) begin
      fails++;
      $display("FAIL stretch_pulse: got %0d pulses at cycle %0d, required 1 at %0d",
               err_pulses - p0, last_err_cyc, fall_at[9] + 2);
    end
    tests++;
    if ({locked, err_count} !== {1'b0, 8'd1}) begin
      fails++;
      $display("FAIL stretch_state: got locked %b count %0d, required 0 1", locked, err_count);
    end
    drive_lines(0, VT - 1, -1, 0);
    tests++;
    if (fsm_state !== ST_VERIFY) begin
      fails++;
      $display("FAIL stretch_verify: got state %0d, required %0d", fsm_state, ST_VERIFY);
    end
    drive_lines(0, VT - 1, -1, 0);
    tests++;
    if ({locked, err_count} !== {1'b1, 8'd1}) begin
      fails++;
      $display("FAIL stretch_relock: got locked %b count %0d, required 1 1", locked, err_count);
    end
  endtask

  task automatic test_sync_loss();
    p0 = err_pulses;
    drive_lines(0, 9, 9, HS + 1100);
    drive_lines(10, 10, -1, 0);
    tests++;
    if (err_pulses - p0 != 1 || last_err_cyc != fall_at[9] + LOSS_LAT) begin
      fails++;
      $display("FAIL loss_pulse: got %0d pulses at cycle %0d, required 1 at %0d",
               err_pulses - p0, last_err_cyc, fall_at[9] + LOSS_LAT);
    end
    tests++;
    if (line_len !== 10'd1023) begin
      fails++;
      $display("FAIL loss_saturate: got line_len %0d, required 1023", line_len);
    end
    tests++;
    if ({locked, err_count} !== {1'b0, 8'd2}) begin
      fails++;
      $display("FAIL loss_state: got locked %b count %0d, required 0 2", locked, err_count);
    end
    drive_lines(11, VT - 1, -1, 0);
  endtask

  task automatic test_short_frame();
    p0 = err_pulses;
    drive_lines(0, VT - 2, -1, 0);
    drive_lines(0, 0, -1, 0);
    tests++;
    if (err_pulses - p0 != 1 || fsm_state !== ST_VERIFY) begin
      fails++;
      $display("FAIL short_pulse: got %0d pulses state %0d, required 1 %0d",
               err_pulses - p0, fsm_state, ST_VERIFY);
    end
    tests++;
    if ({frame_lines, err_count} !== {10'(VT - 1), 8'd3}) begin
      fails++;
      $display("FAIL short_counts: got frame_lines %0d count %0d, required %0d 3",
               frame_lines, err_count, VT - 1);
    end
    drive_lines(1, VT - 1, -1, 0);
    drive_lines(0, 0, -1, 0);
    tests++;
    if ({locked, frame_lines} !== {1'b1, 10'(VT)}) begin
      fails++;
      $display("FAIL short_relock: got locked %b frame_lines %0d, required 1 %0d",
               locked, frame_lines, VT);
    end
  endtask

  task automatic test_reset_mid();
    drive_lines(1, 5, -1, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge pxclk);
      hsync = (i >= HS);
      vsync = 1'b1;
    end
    tests++;
    if ({Display, locked} !== 2'b11) begin
      fails++;
      $display("FAIL midrst_pre: got Display %b locked %b, required 1 1", Display, locked);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (all_out !== '0) begin
      fails++;
      $display("FAIL midrst_async: got %h, required 0", all_out);
    end
    repeat (3) @(posedge pxclk);
    @(negedge pxclk);
    rst_n = 1'b1;
    drive_lines(7, VT - 1, -1, 0);
    tests++;
    if ({fsm_state, err_count} !== {ST_SEARCH, 8'd0}) begin
      fails++;
      $display("FAIL midrst_search: got state %0d count %0d, required %0d 0", fsm_state, err_count, ST_SEARCH);
    end
    drive_lines(0, 0, -1, 0);
    tests++;
    if (fsm_state !== ST_VERIFY) begin
      fails++;
      $display("FAIL midrst_verify: got state %0d, required %0d", fsm_state, ST_VERIFY);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_display();
    test_stretch();
    test_sync_loss();
    test_short_frame();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
